// File: rtl/serial_link_sched_if.sv
// Bundle of control, serial-monitor and status signals between the link
// scheduler and its S1/S2 environment.
`timescale 1ns/1ps
interface serial_link_sched_if;
  logic       start;
  logic       sen;
  logic       sd;
  logic       S1_done;
  logic       S2_done;
  logic       updown;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] pkt_cnt;

  modport master (
    output start, sen, sd, S1_done, S2_done,
    input  updown, busy, done, err, pkt_cnt
  );

  modport slave (
    input  start, sen, sd, S1_done, S2_done,
    output updown, busy, done, err, pkt_cnt
  );
endinterface

// File: rtl/serial_link_sched.sv
// Sequences a download/turnaround/upload transfer on a serial link, checking
// frame length and address order while downloading, with a progress timeout.
`timescale 1ns/1ps
module serial_link_sched #(
  parameter int FRAME_BITS = 21,
  parameter int NUM_PKT    = 8,
  parameter int TURN_GAP   = 4,
  parameter int TIMEOUT    = 1023
) (
  input logic               clk,
  input logic               rst,
  serial_link_sched_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_DOWN, S_TURN, S_UP, S_DONE, S_ERR} state_t;

  localparam int BCW = $clog2(FRAME_BITS + 2);
  localparam int GW  = $clog2(TURN_GAP + 1);
  localparam logic [BCW-1:0] BIT_SAT = BCW'(FRAME_BITS + 1);

  state_t         r_state;
  logic           r_sen_q;
  logic [BCW-1:0] r_bit_cnt;
  logic [2:0]     r_addr;
  logic [3:0]     r_pkt_cnt;
  logic [9:0]     r_timer;
  logic [GW-1:0]  r_gap;
  logic           r_updown;
  logic           r_busy;
  logic           r_done;
  logic           r_err;

  logic w_frame_start;
  logic w_frame_end;
  logic w_frame_ok;
  logic w_timeout;

  assign w_frame_start = r_sen_q & ~bus.sen;
  assign w_frame_end   = ~r_sen_q & bus.sen;
  assign w_frame_ok    = (r_bit_cnt == BCW'(FRAME_BITS)) && (r_addr == r_pkt_cnt[2:0]);
  assign w_timeout     = (r_timer == 10'(TIMEOUT - 1));

  // Frame monitor: the idle level of sen is high, so the history starts at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sen_q   <= 1'b1;
      r_bit_cnt <= '0;
      r_addr    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_sen_q <= bus.sen;
      if (w_frame_start) begin
        r_bit_cnt <= BCW'(1);
        r_addr    <= {r_addr[1:0], bus.sd};
      end else if (!bus.sen) begin
        if (r_bit_cnt != BIT_SAT) r_bit_cnt <= r_bit_cnt + BCW'(1);
        if (r_bit_cnt < BCW'(3))  r_addr    <= {r_addr[1:0], bus.sd};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pkt_cnt <= '0;
      r_timer   <= '0;
      r_gap     <= '0;
      r_updown  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_DOWN;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_pkt_cnt <= '0;
            r_timer   <= '0;
          end
        end
        S_DOWN: begin
          // Timeout outranks any frame event landing on the same edge.
          if (w_timeout) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else if (w_frame_end) begin
            if (w_frame_ok) begin
              r_pkt_cnt <= r_pkt_cnt + 4'd1;
              r_timer   <= '0;
              if (r_pkt_cnt == 4'(NUM_PKT - 1)) begin
                r_state <= S_TURN;
                r_gap   <= '0;
              end
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 10'd1;
          end
        end
        S_TURN: begin
          if (w_frame_start) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end else if (r_gap == GW'(TURN_GAP - 1)) begin
            r_state  <= S_UP;
            r_updown <= 1'b1;
            r_timer  <= '0;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        S_UP: begin
          if (w_timeout) begin
            r_state  <= S_ERR;
            r_err    <= 1'b1;
            r_updown <= 1'b0;
          end else if (bus.S1_done && bus.S2_done) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_timer <= r_timer + 10'd1;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_updown <= 1'b0;
          r_busy   <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_updown <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.updown  = r_updown;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.pkt_cnt = r_pkt_cnt;

endmodule

// File: doc/serial_link_sched.md
SERIAL_LINK_SCHED -- requirements
Module: serial_link_sched

Interface
REQ-001 Parameter FRAME_BITS, default 21, meaning serial bits per packet frame (3 address + 18 data).
REQ-002 Parameter NUM_PKT, default 8, meaning packets per download phase.
REQ-003 Parameter TURN_GAP, default 4, meaning idle cycles between download end and updown flip.
REQ-004 Parameter TIMEOUT, default 1023, meaning max cycles without progress before error.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse; begins a transfer sequence when idle.
REQ-008 sen  input  1  serial enable, observed only (low = frame in progress); bench pulls high when undriven.
REQ-009 sd  input  1  serial data, observed only.
REQ-010 S1_done  input  1  level from S1, upload phase complete.
REQ-011 S2_done  input  1  level from S2, upload phase complete.
REQ-012 updown  output  1  direction to S1/S2: 0 = download (S1 -> S2), 1 = upload.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 err  output  1  sticky error flag until next start or reset.
REQ-016 pkt_cnt  output  4  count of valid frames seen in current sequence.

Function
REQ-017 States: IDLE, DOWN, TURN, UP, DONE, ERR; encoding free, registered.
REQ-018 IDLE: updown=0, busy=0; start=1 -> DOWN, clearing pkt_cnt, err, timer, expected address; start ignored in all other states.
REQ-019 DOWN: updown=0; frame monitor active; pkt_cnt==NUM_PKT after a valid frame end -> TURN.
REQ-020 Frame start = sen sampled 1 then 0 on consecutive edges; bit counter reset to 1 on start, +1 each cycle sen==0.
REQ-021 Address capture: first 3 sampled sd bits while sen==0, MSB first.
REQ-022 Frame end = sen sampled 0 then 1; valid iff bit count==FRAME_BITS and captured address==expected address (pkt_cnt[2:0]).
REQ-023 Valid frame end: pkt_cnt +1 on the same edge; timer cleared.
REQ-024 Invalid frame end (wrong length or address): -> ERR next edge, pkt_cnt unchanged.
REQ-025 Bit counter saturates at FRAME_BITS+1; saturation does not itself error, length check at frame end does.
REQ-026 TURN: updown=0, counts TURN_GAP cycles; any frame start seen in TURN -> ERR; gap elapsed -> UP.
REQ-027 UP: updown=1; S1_done and S2_done both high on same sample -> DONE; frame monitor inactive.
REQ-028 DONE: done=1 for exactly one cycle, updown=1, busy=1; -> IDLE next edge (updown returns 0).
REQ-029 ERR: err=1, updown=0, busy=1; -> IDLE next edge; err held until next accepted start.
REQ-030 Timeout: 10-bit timer increments each cycle in DOWN or UP, cleared on valid frame, state entry; reaching TIMEOUT -> ERR.
REQ-031 Frame in progress when DOWN -> TURN transition occurs is impossible (transition only at frame end); frame start and timeout on same edge: timeout wins.
REQ-032 pkt_cnt width 4; no wrap, since DOWN exits at NUM_PKT (NUM_PKT<=15).

Reset
REQ-033 rst low at any time, including mid-frame or mid-UP: state=IDLE, updown=0, busy=0, done=0, err=0, pkt_cnt=0, timer/bit counter/address cleared immediately.
REQ-034 After rst release, first accepted start is the first start pulse sampled high in IDLE.

Verification
REQ-035 start, then 8 frames of 21 low-sen cycles with addresses 0..7, then S1_done=S2_done=1 -> pkt_cnt=8, updown rises 4 cycles after 8th frame end, done pulses one cycle, busy falls.
REQ-036 Frame 3 sent with 20 bits -> pkt_cnt stays 3, err=1, back to IDLE with updown=0.
REQ-037 Frame 2 carries address 5 -> err=1, pkt_cnt=2.
REQ-038 start, no sen activity for 1023 cycles -> err=1, IDLE.
REQ-039 rst asserted during frame 5 bit 10 -> all outputs zero immediately; new start and 8 clean frames succeed.
REQ-040 Only S1_done high in UP for 1023 cycles -> ERR via timeout; done never pulses.
